// File: rtl/rps_auto_player_pkg.sv
// Shared types for the rock-paper-scissors auto player: move and FSM state enums
// plus the move-to-pin encoder.
package rps_env_pkg;

  typedef enum logic [1:0] {
    MOVE_R,
    MOVE_P,
    MOVE_S
  } rps_move_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    DONE
  } rps_player_state_t;

  // Pin order is {r, p, s}.
  function automatic logic [2:0] move_to_onehot(rps_move_t m);
    case (m)
      MOVE_R:  return 3'b100;
      MOVE_P:  return 3'b010;
      MOVE_S:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rps_auto_player_if.sv
// Player-side pin bundle toward rps_dut: one-hot move lines, go strobe,
// round score and the DUT busy flag.
interface rps_auto_player_if;
  logic r;
  logic p;
  logic s;
  logic go;
  logic score;
  logic dut_busy;

  modport master (output r, p, s, go, input score, dut_busy);
  modport slave  (input r, p, s, go, output score, dut_busy);
endinterface

// File: rtl/rps_auto_player_move_gen.sv
// Move source for the auto player. Define RPS_LFSR_EN for an 8-bit Fibonacci
// LFSR (x^8+x^6+x^5+x^4+1); otherwise a fixed R,P,S rotation.
module rps_move_gen
  import rps_env_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      reload,
  input  logic      step,
  output rps_move_t move
);

`ifdef RPS_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reload) begin
      lfsr_d = SEED;
    end else if (step) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The current register value is the move; it advances only after a go.
  assign move = rps_move_t'(2'(lfsr_q % 8'd3));
`else
  rps_move_t rot_q, rot_d;

  always_comb begin
    rot_d = rot_q;
    if (reload) begin
      rot_d = MOVE_R;
    end else if (step) begin
      case (rot_q)
        MOVE_R:  rot_d = MOVE_P;
        MOVE_P:  rot_d = MOVE_S;
        default: rot_d = MOVE_R;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q <= MOVE_R;
    end else begin
      rot_q <= rot_d;
    end
  end

  assign move = rot_q;
`endif

endmodule

// File: rtl/rps_auto_player.sv
// Hardware rock-paper-scissors player driving one rps_dut port: issues moves under
// the dut_busy handshake and tallies games/wins. Move source selected by RPS_LFSR_EN.
module rps_auto_player
  import rps_env_pkg::*;
#(
  parameter int unsigned NUM_GAMES = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  rps_auto_player_if.master  bus,
  output logic [CNT_W-1:0]   games,
  output logic [CNT_W-1:0]   wins,
  output logic               done,
  output logic               timeout_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  rps_player_state_t state_q, state_d;
  logic [CNT_W-1:0]  games_q, games_d;
  logic [CNT_W-1:0]  wins_q, wins_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              timeoutErr_q, timeoutErr_d;
  logic [2:0]        heldMove_q, heldMove_d;

  logic      startAccept;
  logic      issueGo;
  logic      roundEnd;
  logic      timeoutHit;
  logic      lastGame;
  rps_move_t nextMove;

  assign startAccept = start && ((state_q == IDLE) || (state_q == DONE));
  assign issueGo     = (state_q == ISSUE) && !bus.dut_busy;
  assign roundEnd    = (state_q == WAIT_IDLE) && !bus.dut_busy;
  assign timeoutHit  = (state_q == WAIT_BUSY) && !bus.dut_busy &&
                       ((32'(timer_q) + 32'd1) >= TIMEOUT);
  assign lastGame    = (games_q + CNT_W'(1)) == CNT_W'(NUM_GAMES);

  rps_move_gen #(.SEED(SEED)) u_move_gen (
    .clk    (clk),
    .rst    (rst),
    .reload (startAccept),
    .step   (issueGo),
    .move   (nextMove)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      games_q      <= '0;
      wins_q       <= '0;
      timer_q      <= '0;
      timeoutErr_q <= 1'b0;
      heldMove_q   <= '0;
    end else begin
      state_q      <= state_d;
      games_q      <= games_d;
      wins_q       <= wins_d;
      timer_q      <= timer_d;
      timeoutErr_q <= timeoutErr_d;
      heldMove_q   <= heldMove_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = ISSUE;
      ISSUE:      if (!bus.dut_busy) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.dut_busy) begin
          state_d = WAIT_IDLE;
        end else if (timeoutHit) begin
          state_d = DONE;
        end
      end
      WAIT_IDLE:  if (!bus.dut_busy) state_d = lastGame ? DONE : ISSUE;
      default:    state_d = IDLE;
    endcase
  end

  // timer_q counts cycles elapsed since the go that opened the current round.
  always_comb begin
    games_d      = games_q;
    wins_d       = wins_q;
    timer_d      = timer_q;
    timeoutErr_d = timeoutErr_q;
    heldMove_d   = heldMove_q;
    if (startAccept) begin
      games_d      = '0;
      wins_d       = '0;
      timeoutErr_d = 1'b0;
      heldMove_d   = '0;
    end
    if (issueGo) begin
      heldMove_d = move_to_onehot(nextMove);
      timer_d    = TMR_W'(1);
    end
    if (state_q == WAIT_BUSY) begin
      timer_d = timer_q + TMR_W'(1);
    end
    if (timeoutHit) begin
      timeoutErr_d = 1'b1;
      heldMove_d   = '0;
    end
    if (roundEnd) begin
      games_d    = games_q + CNT_W'(1);
      wins_d     = wins_q + CNT_W'(bus.score);
      heldMove_d = '0;
    end
  end

  always_comb begin
    bus.go = issueGo;
    {bus.r, bus.p, bus.s} = issueGo ? move_to_onehot(nextMove) : heldMove_q;
  end

  assign games       = games_q;
  assign wins        = wins_q;
  assign done        = (state_q == DONE);
  assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_rps_auto_player.sv
// Self-checking bench for rps_auto_player: an rps_dut emulator with random busy
// times and scores, checked against a move/score reference model.
module tb_rps_auto_player;
  import rps_env_pkg::*;

`ifdef RPS_LFSR_EN
  localparam int NUM_GAMES = 16;
`else
  localparam int NUM_GAMES = 3;
`endif
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;
  localparam logic [7:0] SEED = 8'hA5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] games;
  logic [CNT_W-1:0] wins;
  logic             done;
  logic             timeoutErr;
  int               testsRun = 0;
  int               testsFailed = 0;

  rps_auto_player_if pif ();

  rps_auto_player #(
    .NUM_GAMES (NUM_GAMES),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .SEED      (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (pif.master),
    .games       (games),
    .wins        (wins),
    .done        (done),
    .timeout_err (timeoutErr)
  );

  always #5 clk = ~clk;

  // Expected {r,p,s} for the idx-th go of a match, computed from the move rules.
  function automatic logic [2:0] refMove(input int idx);
    int m;
`ifdef RPS_LFSR_EN
    int lfsr;
    int fb;
    lfsr = int'(SEED);
    for (int i = 0; i < idx; i++) begin
      fb   = ((lfsr >> 7) ^ (lfsr >> 5) ^ (lfsr >> 4) ^ (lfsr >> 3)) & 1;
      lfsr = ((lfsr << 1) | fb) & 255;
    end
    m = lfsr % 3;
`else
    m = idx % 3;
`endif
    case (m)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    pif.dut_busy = 1'b0;
    pif.score = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      testsRun++;
      if ({pif.r, pif.p, pif.s, pif.go, done, timeoutErr} !== 6'b0 || games !== '0 || wins !== '0) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold: rpsgo/done/err=%b games=%0d wins=%0d, required all zero",
                 {pif.r, pif.p, pif.s, pif.go, done, timeoutErr}, games, wins);
      end
    end
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      testsRun++;
      if (pif.go !== 1'b0 || done !== 1'b0 || {pif.r, pif.p, pif.s} !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL idle_after_reset: go=%b done=%b rps=%b, required 0 0 000",
                 pif.go, done, {pif.r, pif.p, pif.s});
      end
    end
  endtask

  // Runs one full match from IDLE/DONE, emulating rps_dut and checking every cycle.
  task automatic playMatch(input string tag, input bit fixedScore, input int preBusy,
                           input int minBusy, input int maxBusy);
    int issued = 0;
    int eGames = 0;
    int eWins = 0;
    int busyLeft = 0;
    int pendingScore = 0;
    int waitLeft;
    int cycles = 0;
    int failStart;
    bit goDue;
    bit goDueNext;
    bit endNext = 0;
    bit roundActive = 0;
    bit lastDone = 0;
    bit finished = 0;
    bit thisEnd;
    logic [2:0] held = 3'b000;
    logic [2:0] rps;
    logic [2:0] want;

    failStart = testsFailed;
    waitLeft = preBusy;
    goDueNext = (preBusy == 0);
    @(negedge clk);
    start = 1'b1;
    pif.dut_busy = 1'b0;
    pif.score = 1'($urandom);
    #1;
    testsRun++;
    if (pif.go !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s_start_go: go=%b, required 0", tag, pif.go);
    end

    while (!finished && cycles < 4000 && testsFailed == failStart) begin
      @(negedge clk);
      cycles++;
      goDue = goDueNext;
      goDueNext = 1'b0;
      thisEnd = 1'b0;
      start = lastDone ? 1'b0 : 1'($urandom_range(0, 1));
      pif.score = 1'($urandom);
      if (waitLeft > 0) begin
        pif.dut_busy = 1'b1;
        waitLeft--;
        goDueNext = (waitLeft == 0);
      end else if (busyLeft > 0) begin
        pif.dut_busy = 1'b1;
        busyLeft--;
        endNext = (busyLeft == 0);
      end else begin
        pif.dut_busy = 1'b0;
        if (endNext) begin
          thisEnd = 1'b1;
          endNext = 1'b0;
          pif.score = 1'(pendingScore);
        end
      end
      #1;
      rps = {pif.r, pif.p, pif.s};

      testsRun++;
      if (games !== CNT_W'(eGames) || wins !== CNT_W'(eWins)) begin
        testsFailed++;
        $display("[TB] FAIL %s_counters: games=%0d wins=%0d, required %0d %0d",
                 tag, games, wins, eGames, eWins);
      end
      testsRun++;
      if ($isunknown(rps) || $countones(rps) > 1) begin
        testsFailed++;
        $display("[TB] FAIL %s_onehot: rps=%b, required at most one bit set", tag, rps);
      end

      if (lastDone) begin
        testsRun++;
        if (done !== 1'b1 || pif.go !== 1'b0 || rps !== 3'b000 || timeoutErr !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL %s_done: done=%b go=%b rps=%b err=%b, required 1 0 000 0",
                   tag, done, pif.go, rps, timeoutErr);
        end
        finished = 1'b1;
      end else begin
        testsRun++;
        if (done !== 1'b0 || pif.go !== goDue) begin
          testsFailed++;
          $display("[TB] FAIL %s_go: go=%b done=%b at game %0d, required go=%b done=0",
                   tag, pif.go, done, issued, goDue);
        end
        if (pif.go === 1'b1) want = refMove(issued);
        else if (roundActive) want = held;
        else want = 3'b000;
        testsRun++;
        if (rps !== want) begin
          testsFailed++;
          $display("[TB] FAIL %s_move: rps=%b at game %0d, required %b", tag, rps, issued, want);
        end
        if (pif.go === 1'b1) begin
          held = want;
          roundActive = 1'b1;
          issued++;
          busyLeft = $urandom_range(minBusy, maxBusy);
          pendingScore = fixedScore ? int'(((issued - 1) % 3) != 1) : int'($urandom_range(0, 1));
        end
        if (thisEnd) begin
          eGames++;
          eWins += pendingScore;
          roundActive = 1'b0;
          if (eGames == NUM_GAMES) lastDone = 1'b1;
          else goDueNext = 1'b1;
        end
      end
    end

    if (!finished) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_end: match not finished after %0d cycles, required done", tag, cycles);
    end

    // Counters and done must stay frozen while the DUT pins wiggle.
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pif.dut_busy = 1'($urandom);
      pif.score = 1'($urandom);
      #1;
      testsRun++;
      if (done !== 1'b1 || pif.go !== 1'b0 || games !== CNT_W'(eGames) || wins !== CNT_W'(eWins)) begin
        testsFailed++;
        $display("[TB] FAIL %s_frozen: done=%b go=%b games=%0d wins=%0d, required 1 0 %0d %0d",
                 tag, done, pif.go, games, wins, eGames, eWins);
      end
    end
    pif.dut_busy = 1'b0;
  endtask

  task automatic test_rotation();
    playMatch("rotation", 1'b1, 0, 4, 4);
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m < 4; m++) begin
      playMatch("random_match", 1'b0, 0, 1, 6);
    end
  endtask

  task automatic test_busy_at_issue();
    playMatch("busy_at_issue", 1'b0, 10, 1, 3);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    start = 1'b1;
    pif.dut_busy = 1'b0;
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    testsRun++;
    if (pif.go !== 1'b1 || {pif.r, pif.p, pif.s} !== refMove(0)) begin
      testsFailed++;
      $display("[TB] FAIL timeout_go: go=%b rps=%b, required 1 %b", pif.go, {pif.r, pif.p, pif.s}, refMove(0));
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      #1;
      testsRun++;
      if (k < TIMEOUT) begin
        if (timeoutErr !== 1'b0 || done !== 1'b0 || pif.go !== 1'b0 || {pif.r, pif.p, pif.s} !== refMove(0)) begin
          testsFailed++;
          $display("[TB] FAIL timeout_wait: cycle %0d err=%b done=%b go=%b rps=%b, required 0 0 0 %b",
                   k, timeoutErr, done, pif.go, {pif.r, pif.p, pif.s}, refMove(0));
        end
      end else begin
        if (timeoutErr !== 1'b1 || done !== 1'b1 || games !== '0 || {pif.r, pif.p, pif.s} !== 3'b000) begin
          testsFailed++;
          $display("[TB] FAIL timeout_hit: cycle %0d err=%b done=%b games=%0d rps=%b, required 1 1 0 000",
                   k, timeoutErr, done, games, {pif.r, pif.p, pif.s});
        end
      end
    end
    @(negedge clk);
    start = 1'b1;
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    testsRun++;
    if (timeoutErr !== 1'b0 || done !== 1'b0 || pif.go !== 1'b1 || {pif.r, pif.p, pif.s} !== refMove(0)) begin
      testsFailed++;
      $display("[TB] FAIL timeout_restart: err=%b done=%b go=%b rps=%b, required 0 0 1 %b",
               timeoutErr, done, pif.go, {pif.r, pif.p, pif.s}, refMove(0));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    @(negedge clk);
    start = 1'b1;
    pif.dut_busy = 1'b0;
    pif.score = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    testsRun++;
    if (pif.go !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_go1: go=%b, required 1", pif.go);
    end
    @(negedge clk); pif.dut_busy = 1'b1;
    @(negedge clk); pif.dut_busy = 1'b1;
    @(negedge clk); pif.dut_busy = 1'b0; pif.score = 1'b1;
    @(negedge clk); pif.score = 1'b0;
    #1;
    testsRun++;
    if (pif.go !== 1'b1 || games !== 8'd1 || wins !== 8'd1 || {pif.r, pif.p, pif.s} !== refMove(1)) begin
      testsFailed++;
      $display("[TB] FAIL midreset_go2: go=%b games=%0d wins=%0d rps=%b, required 1 1 1 %b",
               pif.go, games, wins, {pif.r, pif.p, pif.s}, refMove(1));
    end
    @(negedge clk); pif.dut_busy = 1'b1;
    @(negedge clk); pif.dut_busy = 1'b1; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    testsRun++;
    if (games !== '0 || wins !== '0 || {pif.r, pif.p, pif.s, pif.go, done, timeoutErr} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_clear: games=%0d wins=%0d rpsgo/done/err=%b, required all zero",
               games, wins, {pif.r, pif.p, pif.s, pif.go, done, timeoutErr});
    end
    @(negedge clk); pif.dut_busy = 1'b0;
    #1;
    testsRun++;
    if (pif.go !== 1'b0 || {pif.r, pif.p, pif.s} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL midreset_idle: go=%b rps=%b, required 0 000", pif.go, {pif.r, pif.p, pif.s});
    end
    playMatch("restart", 1'b1, 0, 4, 4);
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_back_to_back();
    test_busy_at_issue();
    test_timeout();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
